// File: rtl/synth_mac_pkg.sv
// Shared types and constants for the synthesis-window MAC scheduler.
package synth_mac_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        PUSH  = 2'd3
    } mac_state_e;

    // cfg_sel encodings.
    localparam logic [1:0] CFG_SEL_BASE   = 2'd0;
    localparam logic [1:0] CFG_SEL_INIT   = 2'd1;
    localparam logic [1:0] CFG_SEL_LAUNCH = 2'd2;

    // Tap geometry: 8 taps, 128 words apart in sample RAM, 64 apart in the window.
    localparam int TAPS           = 8;
    localparam int TAP_STRIDE_W   = 128;
    localparam int TAP_STRIDE_IDX = 64;
    localparam int TAP_W          = $clog2(TAPS);

    // Window index and output-count widths.
    localparam int IDX_W = 9;
    localparam int N_W   = 6;

    // Launch word fields: [8:0] start idx, [21:16] output count.
    localparam int LAUNCH_IDX_LSB = 0;
    localparam int LAUNCH_N_LSB   = 16;

    // Window index of a tap; wraps modulo 512 through the 9-bit result.
    function automatic logic [IDX_W-1:0] tap_win_idx(input logic [IDX_W-1:0] idx,
                                                     input logic [TAP_W-1:0] tap);
        logic [IDX_W-1:0] step;
        step = IDX_W'(TAP_STRIDE_IDX) * IDX_W'(tap);
        return idx + step;
    endfunction

endpackage

// File: rtl/synth_res_fifo.sv
// Synchronous result FIFO with a registered head word.
// res_valid/res_ready style handshake: a word leaves on any clock edge where
// valid and pop are both high; rdata holds the head steadily while valid is high.
module synth_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [W-1:0]     head_q;
    logic [W-1:0]     head_d;
    logic             pop_en;
    logic             push_en;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the slot in the same cycle.
    assign pop_en  = pop && (count_q != '0);
    assign push_en = push && ((count_q != CNT_W'(DEPTH)) || pop_en);

    assign full  = (count_q == CNT_W'(DEPTH));
    assign valid = (count_q != '0);
    assign rdata = head_q;

    // Next head: the following stored word on a pop, or the incoming word
    // when it becomes the only entry.
    always_comb begin
        head_d = head_q;
        if (pop_en) begin
            if (count_q > CNT_W'(1)) begin
                head_d = mem_q[rd_ptr_q + PTR_W'(1)];
            end else if (push_en) begin
                head_d = wdata;
            end
        end else if ((count_q == '0) && push_en) begin
            head_d = wdata;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/synth_mac_scheduler.sv
// Autonomous sequencer for the synthesis-window MAC: walks N outputs of
// 8 taps each, sharing the sample-RAM read port with CPU loads.
module synth_mac_scheduler
    import synth_mac_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_sel,
    input  logic [31:0]       cfg_wdata,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_rvalid,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata,
    output logic [8:0]        win_idx,
    input  logic [17:0]       win_coef,
    output logic              res_valid,
    output logic [31:0]       res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [1:0]        dbg_state
);

    mac_state_e        state_q;
    mac_state_e        state_d;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       init_q;
    logic [IDX_W-1:0]  idx_q;
    logic [N_W-1:0]    n_q;
    logic [TAP_W-1:0]  tap_q;
    logic              cfg_err_q;
    logic              done_q;
    logic              cpu_rvalid_q;

    logic              v1_q;
    logic              first1_q;
    logic [31:0]       accu_q;

    logic              mac_issue;
    logic              tap_accept;
    logic              do_push;
    logic              last_push;
    logic              cfg_idle;
    logic              cfg_busy;
    logic              fifo_full;
    logic [N_W-1:0]    launch_n;
    logic [IDX_W-1:0]  launch_idx;
    logic [ADDR_W-1:0] mac_addr;
    logic [31:0]       coef_ext;
    logic [31:0]       prod;

    assign launch_idx = cfg_wdata[LAUNCH_IDX_LSB +: IDX_W];
    assign launch_n   = cfg_wdata[LAUNCH_N_LSB +: N_W];
    assign cfg_idle   = cfg_wr && (state_q == IDLE);
    assign cfg_busy   = cfg_wr && (state_q != IDLE);

    // The CPU owns the port whenever it asks; a blocked tap simply retries.
    assign mac_issue  = (state_q == ISSUE);
    assign tap_accept = mac_issue && !cpu_rd;
    assign mac_addr   = base_q + ADDR_W'(TAP_STRIDE_W) * ADDR_W'(tap_q);
    assign ram_rd     = cpu_rd || mac_issue;
    assign ram_addr   = cpu_rd ? cpu_addr : mac_addr;
    assign win_idx    = tap_win_idx(idx_q, tap_q);

    // Only the low 32 bits of the product are kept, so a 32x32 multiply of the
    // sign-extended coefficient gives the same bits as a full signed product.
    assign coef_ext = {{14{win_coef[17]}}, win_coef};
    assign prod     = coef_ext * ram_rdata;

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_state  = state_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d   = state_q;
        do_push   = 1'b0;
        last_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_wr && (cfg_sel == CFG_SEL_LAUNCH) && (launch_n != '0)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (tap_accept && (tap_q == TAP_W'(TAPS - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!v1_q) begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    do_push   = 1'b1;
                    last_push = (n_q == N_W'(1));
                    state_d   = last_push ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job registers: configuration latch, tap counter, per-output advance,
    // sticky config error and the done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            base_q    <= '0;
            init_q    <= '0;
            idx_q     <= '0;
            n_q       <= '0;
            tap_q     <= '0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cfg_busy) begin
                cfg_err_q <= 1'b1;
            end else if (cfg_idle) begin
                cfg_err_q <= 1'b0;
            end
            if (cfg_idle) begin
                case (cfg_sel)
                    CFG_SEL_BASE: base_q <= cfg_wdata[ADDR_W-1:0];
                    CFG_SEL_INIT: init_q <= cfg_wdata;
                    CFG_SEL_LAUNCH: begin
                        idx_q <= launch_idx;
                        n_q   <= launch_n;
                        tap_q <= '0;
                        if (launch_n == '0) begin
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Counter wraps 7 -> 0, ready for the next output.
            if (tap_accept) begin
                tap_q <= tap_q + TAP_W'(1);
            end
            if (do_push) begin
                base_q <= base_q + ADDR_W'(1);
                idx_q  <= idx_q + IDX_W'(1);
                n_q    <= n_q - N_W'(1);
                if (last_push) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    // MAC pipeline: tagged issue -> data cycle -> accumulate; tap 0 seeds
    // the accumulator with the init value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            v1_q         <= 1'b0;
            first1_q     <= 1'b0;
            accu_q       <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            v1_q         <= tap_accept;
            first1_q     <= tap_accept && (tap_q == '0);
            cpu_rvalid_q <= cpu_rd;
            if (v1_q) begin
                accu_q <= (first1_q ? init_q : accu_q) + prod;
            end
        end
    end

    synth_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_res_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (do_push),
        .wdata  (accu_q),
        .pop    (res_ready),
        .full   (fifo_full),
        .valid  (res_valid),
        .rdata  (res_data)
    );

endmodule

// File: tb/tb_synth_mac_scheduler.sv
// Self-checking bench for synth_mac_scheduler: RAM/ROM models, driver tasks,
// scoreboard queues for results, CPU reads and MAC issues, final report.
module tb_synth_mac_scheduler;
    import synth_mac_pkg::*;

    localparam int ADDR_W     = 19;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              cfg_wr;
    logic [1:0]        cfg_sel;
    logic [31:0]       cfg_wdata;
    logic              cpu_rd;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rvalid;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_rdata;
    logic [8:0]        win_idx;
    logic [17:0]       win_coef;
    logic              res_valid;
    logic [31:0]       res_data;
    logic              res_ready;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cyc = 0;
    int done_cnt = 0;

    logic [31:0]         exp_q[$];
    logic [31:0]         cpu_q[$];
    logic [ADDR_W+8:0]   issue_q[$];

    logic signed [17:0]  rom_mem [512];
    logic [31:0]         ram_mem [int];
    logic [31:0]         ram_default = 32'd0;

    synth_mac_scheduler #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_addr   (cpu_addr),
        .cpu_rvalid (cpu_rvalid),
        .ram_rd     (ram_rd),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .win_idx    (win_idx),
        .win_coef   (win_coef),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .dbg_state  (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a);
        if (ram_mem.exists(int'(a))) return ram_mem[int'(a)];
        return ram_default;
    endfunction

    // Reference result for output k of a job.
    function automatic logic [31:0] model_out(input logic [ADDR_W-1:0] base, input logic [31:0] init,
                                              input logic [8:0] idx, input int k);
        logic [31:0]       acc;
        logic [ADDR_W-1:0] a;
        logic [8:0]        i;
        longint            p;
        acc = init;
        for (int t = 0; t < 8; t++) begin
            a = base + ADDR_W'(k) + ADDR_W'(128 * t);
            i = idx + 9'(k) + 9'(64 * t);
            p = longint'(rom_mem[i]) * longint'($signed(ram_word(a)));
            acc = acc + p[31:0];
        end
        return acc;
    endfunction

    // Sample RAM (1-cycle read) and registered window ROM.
    always @(posedge clk) begin
        if (ram_rd) ram_rdata <= ram_word(ram_addr);
        win_coef <= rom_mem[win_idx];
    end

    // Monitor: scoreboards for results, CPU reads and MAC issue stream.
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (cpu_rvalid) begin
            check("cpu_q_nonempty", 32'(cpu_q.size() != 0), 32'd1);
            if (cpu_q.size() != 0) check("cpu_rdata", ram_rdata, cpu_q.pop_front());
        end
        if (ram_rd && !cpu_rd) begin
            check("issue_q_nonempty", 32'(issue_q.size() != 0), 32'd1);
            if (issue_q.size() != 0) check("issue_addr_idx", 32'({ram_addr, win_idx}), 32'(issue_q.pop_front()));
        end
        if (res_valid && res_ready) begin
            check("res_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("res_data", res_data, exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
        cfg_wr    = 1'b1;
        cfg_sel   = sel;
        cfg_wdata = data;
        tick(1);
        cfg_wr    = 1'b0;
    endtask

    task automatic launch_job(input logic [ADDR_W-1:0] base, input logic [31:0] init,
                              input logic [8:0] idx, input logic [5:0] n, input bit use_model);
        for (int k = 0; k < int'(n); k++) begin
            if (use_model) exp_q.push_back(model_out(base, init, idx, k));
            for (int t = 0; t < 8; t++) begin
                issue_q.push_back({base + ADDR_W'(k) + ADDR_W'(128 * t), idx + 9'(k) + 9'(64 * t)});
            end
        end
        cfg_write(CFG_SEL_BASE, 32'(base));
        cfg_write(CFG_SEL_INIT, init);
        cfg_write(CFG_SEL_LAUNCH, {10'd0, n, 7'd0, idx});
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && !res_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic setup_t1_mem();
        for (int i = 0; i < 512; i++) rom_mem[i] = 18'sd0;
        for (int t = 0; t < 8; t++) rom_mem[64 * t] = 18'sd2;
        ram_mem.delete();
        ram_default = 32'd0;
        for (int t = 0; t < 8; t++) ram_mem[128 * t] = 32'(t + 1);
    endtask

    // Watchdog.
    initial begin
        #500000;
        check("watchdog", 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        logic [ADDR_W-1:0] a;
        resetn = 1'b0; cfg_wr = 1'b0; cfg_sel = 2'd0; cfg_wdata = 32'd0;
        cpu_rd = 1'b0; cpu_addr = '0; res_ready = 1'b1;
        for (int i = 0; i < 512; i++) rom_mem[i] = 18'sd0;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_ram_rd", 32'(ram_rd), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        resetn = 1'b1;
        tick(2);

        // Test 1: single output, known value 72, 11 busy cycles.
        setup_t1_mem();
        busy_cyc = 0; done_cnt = 0;
        exp_q.push_back(32'd72);
        launch_job('0, 32'd0, 9'd0, 6'd1, 1'b0);
        wait_idle(100, "t1_timeout");
        check("t1_busy_cycles", 32'(busy_cyc), 32'd11);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);

        // N = 0: done next cycle, stays idle.
        done_cnt = 0;
        cfg_write(CFG_SEL_LAUNCH, {10'd0, 6'd0, 7'd0, 9'd3});
        check("n0_busy", 32'(busy), 32'd0);
        check("n0_done", 32'(done), 32'd1);
        tick(1);
        check("n0_done_cleared", 32'(done), 32'd0);
        check("n0_done_cnt", 32'(done_cnt), 32'd1);

        // Test 2: idx wrap 510, 511, 0; ROM returns its index; RAM all 1.
        for (int i = 0; i < 512; i++) rom_mem[i] = 18'(i);
        ram_mem.delete();
        ram_default = 32'd1;
        busy_cyc = 0; done_cnt = 0;
        launch_job('0, 32'd0, 9'd510, 6'd3, 1'b1);
        wait_idle(200, "t2_timeout");
        check("t2_busy_cycles", 32'(busy_cyc), 32'd33);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // Test 3: CPU reads every other cycle during a job.
        setup_t1_mem();
        busy_cyc = 0; done_cnt = 0;
        exp_q.push_back(32'd72);
        launch_job('0, 32'd0, 9'd0, 6'd1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                a = ADDR_W'($urandom_range(4096, 8191));
                if (!ram_mem.exists(int'(a))) ram_mem[int'(a)] = $urandom;
                cpu_rd   = 1'b1;
                cpu_addr = a;
                cpu_q.push_back(ram_word(a));
            end else begin
                cpu_rd = 1'b0;
            end
            tick(1);
        end
        cpu_rd = 1'b0;
        wait_idle(100, "t3_timeout");
        tick(2);
        check("t3_busy_cycles", 32'(busy_cyc), 32'd19);
        check("t3_cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);

        // Test 4: FIFO backpressure with N = 6.
        for (int i = 0; i < 512; i++) rom_mem[i] = 18'($urandom_range(0, 262143));
        ram_mem.delete();
        ram_default = 32'd1;
        for (int i = 0; i < 1024; i++) ram_mem[i] = $urandom;
        res_ready = 1'b0;
        busy_cyc = 0; done_cnt = 0;
        launch_job(ADDR_W'(100), 32'h100, 9'd7, 6'd6, 1'b1);
        tick(80);
        check("t4_busy_stall", 32'(busy), 32'd1);
        check("t4_state_push", 32'(dbg_state), 32'(PUSH));
        check("t4_res_valid", 32'(res_valid), 32'd1);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        check("t4_nothing_popped", 32'(exp_q.size()), 32'd6);
        res_ready = 1'b1;
        wait_idle(200, "t4_timeout");
        check("t4_done_cnt", 32'(done_cnt), 32'd1);

        // Test 5: config while busy is ignored and flags cfg_err.
        busy_cyc = 0; done_cnt = 0;
        launch_job(ADDR_W'(3), 32'd5, 9'd200, 6'd2, 1'b1);
        tick(3);
        cfg_write(CFG_SEL_LAUNCH, {10'd0, 6'd7, 7'd0, 9'd5});
        cfg_write(CFG_SEL_BASE, 32'd999);
        check("t5_cfg_err_set", 32'(cfg_err), 32'd1);
        wait_idle(200, "t5_timeout");
        check("t5_busy_cycles", 32'(busy_cyc), 32'd22);
        check("t5_done_cnt", 32'(done_cnt), 32'd1);
        check("t5_err_sticky", 32'(cfg_err), 32'd1);
        cfg_write(CFG_SEL_BASE, 32'd0);
        check("t5_err_cleared", 32'(cfg_err), 32'd0);

        // Test 6: reset mid-ISSUE with a result already buffered.
        res_ready = 1'b0;
        launch_job('0, 32'd0, 9'd0, 6'd3, 1'b1);
        tick(14);
        check("t6_pre_state_issue", 32'(dbg_state), 32'(ISSUE));
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        exp_q.delete();
        issue_q.delete();
        done_cnt = 0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_res_valid", 32'(res_valid), 32'd0);
        check("t6_state", 32'(dbg_state), 32'(IDLE));
        res_ready = 1'b1;
        tick(30);
        check("t6_no_stray_push", 32'(res_valid), 32'd0);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        setup_t1_mem();
        busy_cyc = 0;
        exp_q.push_back(32'd72);
        launch_job('0, 32'd0, 9'd0, 6'd1, 1'b0);
        wait_idle(100, "t6_timeout");
        check("t6_busy_cycles", 32'(busy_cyc), 32'd11);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("end_issue_q_drained", 32'(issue_q.size()), 32'd0);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
